// File: rtl/rep_pkg.sv
// Shared types and helpers for the repetition matcher: operating modes,
// per-channel FSM states and a saturating increment.
package rep_pkg;

  typedef enum logic [1:0] {
    REP_CONSECUTIVE,
    REP_GOTO,
    REP_NONCONSEC
  } rep_mode_e;

  typedef enum logic {
    S_IDLE,
    S_ARMED
  } state_e;

  // Increment v, clamping at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= top) ? top : v + 32'd1;
  endfunction

endpackage

// File: rtl/rep_channel.sv
// One repetition-checking channel: occurrence counter, window timer, latched
// bounds and the IDLE/ARMED FSM. All outputs come straight from registers.
module rep_channel import rep_pkg::*; #(
  parameter int        CNT_W   = 8,
  parameter rep_mode_e MODE    = REP_CONSECUTIVE,
  parameter int        TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_min,
  input  logic [CNT_W-1:0] cfg_max,
  input  logic             start,
  input  logic             ev,
  output logic             match,
  output logic             done,
  output logic             fail,
  output logic             busy,
  output logic             start_drop,
  output logic [CNT_W-1:0] cnt
);

  localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] min_reg, min_next;
  logic [CNT_W-1:0] max_reg, max_next;
  logic [TW-1:0]    timer_reg, timer_next;
  logic             match_reg, match_next;
  logic             done_reg, done_next;
  logic             fail_reg, fail_next;
  logic             drop_reg, drop_next;

  logic             cfg_ok, timeout, in_range;
  logic [CNT_W-1:0] cnt_inc, cnt_new;

  assign cfg_ok   = (cfg_min != '0) && (cfg_min <= cfg_max);
  assign cnt_inc  = CNT_W'(sat_inc(32'(cnt_reg), CNT_W));
  assign cnt_new  = ev ? cnt_inc : cnt_reg;
  assign in_range = (cnt_new >= min_reg) && (cnt_new <= max_reg);
  assign timeout  = (timer_reg == T_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    min_next   = min_reg;
    max_next   = max_reg;
    timer_next = timer_reg;
    match_next = 1'b0;
    done_next  = 1'b0;
    fail_next  = 1'b0;
    drop_next  = 1'b0;
    if (MODE == REP_CONSECUTIVE) begin
      // Run length of the current ev burst; bounds are read live.
      cnt_next   = ev ? cnt_inc : '0;
      match_next = ev && cfg_ok && (cnt_next >= cfg_min) && (cnt_next <= cfg_max);
    end else begin
      case (state_reg)
        S_IDLE: begin
          cnt_next   = '0;
          timer_next = '0;
          if (start) begin
            if (cfg_ok) begin
              state_next = S_ARMED;
              min_next   = cfg_min;
              max_next   = cfg_max;
            end else begin
              drop_next = 1'b1;
            end
          end
        end
        S_ARMED: begin
          drop_next  = start;
          cnt_next   = cnt_new;
          timer_next = timer_reg + 1'b1;
          if (MODE == REP_GOTO) begin
            match_next = ev && in_range;
            if (ev && (cnt_new == max_reg)) begin
              done_next  = 1'b1;
              state_next = S_IDLE;
            end else if (timeout) begin
              done_next  = (cnt_new >= min_reg);
              fail_next  = (cnt_new < min_reg);
              state_next = S_IDLE;
            end
          end else begin
            // An event beyond the upper bound is an overshoot.
            if (ev && (cnt_reg == max_reg)) begin
              fail_next  = 1'b1;
              state_next = S_IDLE;
            end else begin
              match_next = in_range;
              if (timeout) begin
                done_next  = in_range;
                fail_next  = !in_range;
                state_next = S_IDLE;
              end
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      min_reg   <= '0;
      max_reg   <= '0;
      timer_reg <= '0;
      match_reg <= 1'b0;
      done_reg  <= 1'b0;
      fail_reg  <= 1'b0;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      min_reg   <= min_next;
      max_reg   <= max_next;
      timer_reg <= timer_next;
      match_reg <= match_next;
      done_reg  <= done_next;
      fail_reg  <= fail_next;
      drop_reg  <= drop_next;
    end
  end

  assign match      = match_reg;
  assign done       = done_reg;
  assign fail       = fail_reg;
  assign start_drop = drop_reg;
  assign busy       = (state_reg == S_ARMED);
  assign cnt        = cnt_reg;

endmodule

// File: rtl/repetition_matcher.sv
// Multi-channel SVA-style repetition checker ([*m:n], [->m:n], [=m:n]);
// channels are independent and share only the cfg bounds.
module repetition_matcher import rep_pkg::*; #(
  parameter int        NUM_CH  = 4,
  parameter int        CNT_W   = 8,
  parameter rep_mode_e MODE    = REP_CONSECUTIVE,
  parameter int        TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CNT_W-1:0]        cfg_min,
  input  logic [CNT_W-1:0]        cfg_max,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       ev,
  output logic [NUM_CH-1:0]       match,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       fail,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       start_drop,
  output logic [NUM_CH*CNT_W-1:0] cnt
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      rep_channel #(
        .CNT_W   (CNT_W),
        .MODE    (MODE),
        .TIMEOUT (TIMEOUT)
      ) u_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_min    (cfg_min),
        .cfg_max    (cfg_max),
        .start      (start[gi]),
        .ev         (ev[gi]),
        .match      (match[gi]),
        .done       (done[gi]),
        .fail       (fail[gi]),
        .busy       (busy[gi]),
        .start_drop (start_drop[gi]),
        .cnt        (cnt[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_repetition_matcher.sv
// Directed bench: one matcher per mode (consecutive, goto, non-consecutive),
// each scenario task checks its own hand-computed expectations.
module tb_repetition_matcher;
  import rep_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cfg_min, cfg_max;
  logic [3:0]  c_start, c_ev, g_start, g_ev, n_start, n_ev;
  logic [3:0]  c_match, c_done, c_fail, c_busy, c_drop;
  logic [3:0]  g_match, g_done, g_fail, g_busy, g_drop;
  logic [3:0]  n_match, n_done, n_fail, n_busy, n_drop;
  logic [31:0] c_cnt, g_cnt, n_cnt;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  repetition_matcher #(.NUM_CH(4), .CNT_W(8), .MODE(REP_CONSECUTIVE), .TIMEOUT(64)) u_con (
    .clk(clk), .rst_n(rst_n), .cfg_min(cfg_min), .cfg_max(cfg_max), .start(c_start), .ev(c_ev),
    .match(c_match), .done(c_done), .fail(c_fail), .busy(c_busy), .start_drop(c_drop), .cnt(c_cnt));

  repetition_matcher #(.NUM_CH(4), .CNT_W(8), .MODE(REP_GOTO), .TIMEOUT(64)) u_goto (
    .clk(clk), .rst_n(rst_n), .cfg_min(cfg_min), .cfg_max(cfg_max), .start(g_start), .ev(g_ev),
    .match(g_match), .done(g_done), .fail(g_fail), .busy(g_busy), .start_drop(g_drop), .cnt(g_cnt));

  repetition_matcher #(.NUM_CH(4), .CNT_W(8), .MODE(REP_NONCONSEC), .TIMEOUT(16)) u_nc (
    .clk(clk), .rst_n(rst_n), .cfg_min(cfg_min), .cfg_max(cfg_max), .start(n_start), .ev(n_ev),
    .match(n_match), .done(n_done), .fail(n_fail), .busy(n_busy), .start_drop(n_drop), .cnt(n_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_min = 8'd0; cfg_max = 8'd0;
    c_start = '0; c_ev = '0; g_start = '0; g_ev = '0; n_start = '0; n_ev = '0;
    tick(); tick();
    total++;
    if ({c_match, c_done, c_fail, c_busy, c_drop, c_cnt} !== '0) begin
      bad++; $display("FAIL reset_con got=%0h exp=0", {c_match, c_done, c_fail, c_busy, c_drop, c_cnt});
    end
    total++;
    if ({g_match, g_done, g_fail, g_busy, g_drop, g_cnt, n_match, n_done, n_fail, n_busy, n_drop, n_cnt} !== '0) begin
      bad++; $display("FAIL reset_seq got_g=%0h got_n=%0h exp=0", g_cnt, n_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_con_exact();
    int pulses;
    cfg_min = 8'd5; cfg_max = 8'd5;
    c_ev[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (c_match[0] !== (i == 4)) begin
        bad++; $display("FAIL con5_run5_cycle%0d got=%b exp=%b", i, c_match[0], (i == 4));
      end
    end
    c_ev[0] = 1'b0;
    tick();
    total++;
    if (c_match[0] !== 1'b0 || c_cnt[7:0] !== 8'd0) begin
      bad++; $display("FAIL con5_drop got_match=%b got_cnt=%0d exp=0/0", c_match[0], c_cnt[7:0]);
    end
    pulses = 0;
    c_ev[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      pulses += int'(c_match[0]);
    end
    total++;
    if (pulses !== 1 || c_cnt[7:0] !== 8'd7) begin
      bad++; $display("FAIL con5_run7 got_pulses=%0d got_cnt=%0d exp=1/7", pulses, c_cnt[7:0]);
    end
    total++;
    if ({c_done, c_fail, c_busy, c_drop} !== '0) begin
      bad++; $display("FAIL con_quiet got=%0h exp=0", {c_done, c_fail, c_busy, c_drop});
    end
    c_ev[0] = 1'b0;
    tick();
    $display("consecutive min=max=5 checked");
  endtask

  task automatic test_con_range();
    logic [5:0] exp;
    exp = 6'b001110;
    cfg_min = 8'd2; cfg_max = 8'd4;
    c_ev[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (c_match[0] !== exp[i]) begin
        bad++; $display("FAIL con24_cycle%0d got=%b exp=%b", i, c_match[0], exp[i]);
      end
    end
    c_ev[0] = 1'b0;
    tick();
    total++;
    if (c_match[0] !== 1'b0) begin
      bad++; $display("FAIL con24_after got=%b exp=0", c_match[0]);
    end
    $display("consecutive min=2 max=4 checked");
  endtask

  task automatic test_goto();
    cfg_min = 8'd2; cfg_max = 8'd2;
    // cycle 0: start with a simultaneous ev that must not count
    g_start[0] = 1'b1; g_ev[0] = 1'b1;
    tick();
    g_start[0] = 1'b0; g_ev[0] = 1'b0;
    total++;
    if (g_busy[0] !== 1'b1 || g_cnt[7:0] !== 8'd0) begin
      bad++; $display("FAIL goto_arm got_busy=%b got_cnt=%0d exp=1/0", g_busy[0], g_cnt[7:0]);
    end
    for (int c = 1; c <= 9; c++) begin
      g_ev[0] = (c == 5 || c == 9);
      tick();
      if (c == 5) begin
        total++;
        if (g_cnt[7:0] !== 8'd1 || g_match[0] !== 1'b0) begin
          bad++; $display("FAIL goto_ev5 got_cnt=%0d got_match=%b exp=1/0", g_cnt[7:0], g_match[0]);
        end
      end
    end
    g_ev[0] = 1'b0;
    total++;
    if (g_match[0] !== 1'b1 || g_done[0] !== 1'b1 || g_busy[0] !== 1'b0 || g_cnt[7:0] !== 8'd2) begin
      bad++; $display("FAIL goto_done got_m=%b d=%b b=%b cnt=%0d exp=1/1/0/2",
                      g_match[0], g_done[0], g_busy[0], g_cnt[7:0]);
    end
    tick();
    total++;
    if (g_done[0] !== 1'b0 || g_match[0] !== 1'b0 || g_cnt[7:0] !== 8'd0) begin
      bad++; $display("FAIL goto_after got_d=%b m=%b cnt=%0d exp=0/0/0", g_done[0], g_match[0], g_cnt[7:0]);
    end
    $display("goto min=max=2 checked");
  endtask

  task automatic test_goto_timeout();
    cfg_min = 8'd2; cfg_max = 8'd3;
    g_start[1] = 1'b1;
    tick();
    g_start[1] = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      g_ev[1] = (k == 3);
      tick();
      if (k == 63) begin
        total++;
        if (g_fail[1] !== 1'b0 || g_busy[1] !== 1'b1) begin
          bad++; $display("FAIL goto_to_early got_f=%b b=%b exp=0/1", g_fail[1], g_busy[1]);
        end
      end
    end
    g_ev[1] = 1'b0;
    total++;
    if (g_fail[1] !== 1'b1 || g_done[1] !== 1'b0 || g_busy[1] !== 1'b0) begin
      bad++; $display("FAIL goto_timeout got_f=%b d=%b b=%b exp=1/0/0", g_fail[1], g_done[1], g_busy[1]);
    end
    tick();
    $display("goto timeout checked");
  endtask

  task automatic test_nonconsec(input int third);
    int fail_k;
    fail_k = 0;
    cfg_min = 8'd2; cfg_max = 8'd2;
    n_start[0] = 1'b1;
    tick();
    n_start[0] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      n_ev[0] = (k == 2 || k == 5 || (third != 0 && k == 8));
      tick();
      if (fail_k == 0) begin
        if (k >= 5 && k <= 15 && !(third != 0 && k >= 8)) begin
          total++;
          if (n_match[0] !== 1'b1) begin
            bad++; $display("FAIL nc_hold_k%0d got=%b exp=1", k, n_match[0]);
          end
        end
        if (third != 0 && k == 8) begin
          total++;
          if (n_fail[0] !== 1'b1 || n_match[0] !== 1'b0 || n_busy[0] !== 1'b0) begin
            bad++; $display("FAIL nc_overshoot got_f=%b m=%b b=%b exp=1/0/0", n_fail[0], n_match[0], n_busy[0]);
          end
          fail_k = k;
        end
        if (third == 0 && k == 15) begin
          total++;
          if (n_done[0] !== 1'b0) begin
            bad++; $display("FAIL nc_done_early got=%b exp=0", n_done[0]);
          end
        end
        if (third == 0 && k == 16) begin
          total++;
          if (n_done[0] !== 1'b1 || n_fail[0] !== 1'b0 || n_busy[0] !== 1'b0) begin
            bad++; $display("FAIL nc_done got_d=%b f=%b b=%b exp=1/0/0", n_done[0], n_fail[0], n_busy[0]);
          end
        end
      end
    end
    n_ev[0] = 1'b0;
    tick();
    total++;
    if (n_match[0] !== 1'b0 || n_cnt[7:0] !== 8'd0 || n_busy[0] !== 1'b0) begin
      bad++; $display("FAIL nc_idle got_m=%b cnt=%0d b=%b exp=0/0/0", n_match[0], n_cnt[7:0], n_busy[0]);
    end
    $display("non-consecutive third=%0d checked", third);
  endtask

  task automatic test_errors();
    cfg_min = 8'd0; cfg_max = 8'd2;
    g_start[2] = 1'b1;
    tick();
    g_start[2] = 1'b0;
    total++;
    if (g_drop[2] !== 1'b1 || g_busy[2] !== 1'b0) begin
      bad++; $display("FAIL drop_min0 got_drop=%b busy=%b exp=1/0", g_drop[2], g_busy[2]);
    end
    cfg_min = 8'd3; cfg_max = 8'd2;
    g_start[2] = 1'b1;
    tick();
    g_start[2] = 1'b0;
    total++;
    if (g_drop[2] !== 1'b1 || g_busy[2] !== 1'b0) begin
      bad++; $display("FAIL drop_minmax got_drop=%b busy=%b exp=1/0", g_drop[2], g_busy[2]);
    end
    tick();
    total++;
    if (g_drop[2] !== 1'b0) begin
      bad++; $display("FAIL drop_pulse got=%b exp=0", g_drop[2]);
    end
    cfg_min = 8'd2; cfg_max = 8'd2;
    g_start[2] = 1'b1;
    tick();
    g_start[2] = 1'b0; g_ev[2] = 1'b1;
    tick();
    g_ev[2] = 1'b0; g_start[2] = 1'b1;
    tick();
    g_start[2] = 1'b0;
    total++;
    if (g_drop[2] !== 1'b1 || g_busy[2] !== 1'b1 || g_cnt[23:16] !== 8'd1) begin
      bad++; $display("FAIL drop_armed got_drop=%b busy=%b cnt=%0d exp=1/1/1", g_drop[2], g_busy[2], g_cnt[23:16]);
    end
    $display("error paths checked");
  endtask

  task automatic test_reset_indep();
    cfg_min = 8'd3; cfg_max = 8'd5;
    n_start[2] = 1'b1;
    tick();
    n_start[2] = 1'b0; n_ev[2] = 1'b1;
    tick(); tick(); tick();
    n_ev[2] = 1'b0;
    total++;
    if (n_cnt[23:16] !== 8'd3 || n_match[2] !== 1'b1 || n_busy !== 4'b0100) begin
      bad++; $display("FAIL indep_ch2 got_cnt=%0d m=%b busy=%b exp=3/1/0100", n_cnt[23:16], n_match[2], n_busy);
    end
    total++;
    if (n_cnt[15:0] !== 16'd0 || n_cnt[31:24] !== 8'd0 || {n_match[3], n_match[1:0]} !== 3'b000) begin
      bad++; $display("FAIL indep_others got_cnt=%0h match=%b exp=0", n_cnt, n_match);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({n_match, n_done, n_fail, n_busy, n_drop, n_cnt} !== '0 || g_busy !== 4'b0000) begin
      bad++; $display("FAIL async_reset got_cnt=%0h busy=%b gbusy=%b exp=0", n_cnt, n_busy, g_busy);
    end
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    total++;
    if (n_fail !== 4'b0000 || g_fail !== 4'b0000 || n_busy !== 4'b0000) begin
      bad++; $display("FAIL reset_nofail got_nf=%b gf=%b nb=%b exp=0", n_fail, g_fail, n_busy);
    end
    $display("reset mid-window and independence checked");
  endtask

  initial begin
    test_reset();
    test_con_exact();
    test_con_range();
    test_goto();
    test_goto_timeout();
    test_nonconsec(0);
    test_nonconsec(1);
    test_errors();
    test_reset_indep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
